// File: rtl/led_seq_ctrl_if.sv
// Control/status bundle between a pattern-sequencer host and led_seq_ctrl.
// The host drives start/stop/mode requests; the sequencer returns status and LED drives.
interface led_seq_ctrl_if;
  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic       mode_load;
  logic       busy;
  logic       step_tick;
  logic       LED2;
  logic       LED3;
  logic       LED4;
  logic       LED5;

  modport master (
    output start, stop, mode, mode_load,
    input  busy, step_tick, LED2, LED3, LED4, LED5
  );

  modport slave (
    input  start, stop, mode, mode_load,
    output busy, step_tick, LED2, LED3, LED4, LED5
  );
endinterface

// File: rtl/led_seq_ctrl.sv
// Four-LED pattern sequencer: prescaled step tick, RUN/PAUSE/IDLE control and
// tick-aligned mode switching so every LED transition lands on a step boundary.
module led_seq_ctrl #(
  parameter int TICK_DIV = 13_500_000
) (
  input  logic          iclk,
  input  logic          rst_i,
  led_seq_ctrl_if.slave bus
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [3:0]    led;
  logic [1:0]    act_mode;
  logic [1:0]    pend_mode;
  logic          pend_flag;
  logic          dir_left;
  logic          busy;
  logic          step_tick;

  logic          tick;
  logic [1:0]    eff_mode;
  logic          eff_flag;
  logic [3:0]    nxt_led;

  function automatic logic [3:0] init_pat(input logic [1:0] m);
    case (m)
      2'd1, 2'd2: return 4'b1000;
      default:    return 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] step_pat(input logic [1:0] m, input logic [3:0] cur,
                                          input logic left);
    case (m)
      2'd0:    return cur + 4'd1;
      2'd1:    return {cur[0], cur[3:1]};
      2'd2:    return left ? {cur[2:0], 1'b0} : {1'b0, cur[3:1]};
      default: return ~cur;
    endcase
  endfunction

  assign tick     = (state == RUN) && (presc == LAST);
  // A load in the same cycle as start takes priority over the stored pending mode.
  assign eff_mode = bus.mode_load ? bus.mode : pend_mode;
  assign eff_flag = bus.mode_load | pend_flag;
  assign nxt_led  = step_pat(act_mode, led, dir_left);

  always_ff @(posedge iclk) begin
    if (rst_i) begin
      state     <= IDLE;
      presc     <= '0;
      led       <= 4'b0000;
      act_mode  <= 2'd0;
      pend_mode <= 2'd0;
      pend_flag <= 1'b0;
      dir_left  <= 1'b0;
      busy      <= 1'b0;
      step_tick <= 1'b0;
    end else begin
      step_tick <= 1'b0;
      if (bus.mode_load) begin
        pend_mode <= bus.mode;
        pend_flag <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            state     <= RUN;
            busy      <= 1'b1;
            act_mode  <= eff_mode;
            led       <= init_pat(eff_mode);
            dir_left  <= 1'b0;
            presc     <= '0;
            pend_flag <= 1'b0;
          end
        end
        RUN: begin
          if (bus.stop) begin
            // Prescaler freezes here so a resume finishes the interrupted interval.
            state <= PAUSE;
          end else if (tick) begin
            presc     <= '0;
            step_tick <= 1'b1;
            if (pend_flag) begin
              act_mode  <= pend_mode;
              led       <= init_pat(pend_mode);
              dir_left  <= 1'b0;
              pend_flag <= bus.mode_load;
            end else begin
              led <= nxt_led;
              if (act_mode == 2'd2) begin
                if (nxt_led == 4'b0001)      dir_left <= 1'b1;
                else if (nxt_led == 4'b1000) dir_left <= 1'b0;
              end
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
        PAUSE: begin
          if (bus.stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            led   <= 4'b0000;
            presc <= '0;
          end else if (bus.start) begin
            state <= RUN;
            if (eff_flag) begin
              act_mode  <= eff_mode;
              led       <= init_pat(eff_mode);
              dir_left  <= 1'b0;
              presc     <= '0;
              pend_flag <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          led   <= 4'b0000;
          presc <= '0;
        end
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.step_tick = step_tick;
  assign bus.LED2      = led[3];
  assign bus.LED3      = led[2];
  assign bus.LED4      = led[1];
  assign bus.LED5      = led[0];

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Randomized bench for led_seq_ctrl against a step-index reference model.
// Patterns are derived from (mode, steps since pattern start) rather than LED history.
module tb_led_seq_ctrl;

  localparam int TICK_DIV = 4;

  logic iclk = 1'b0;
  logic rst_i;

  led_seq_ctrl_if bus ();

  led_seq_ctrl #(.TICK_DIV(TICK_DIV)) dut (
    .iclk  (iclk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 iclk = ~iclk;

  int errs   = 0;
  int checks = 0;

  // Reference model: 0 idle, 1 run, 2 pause; m_pos counts steps since the pattern began.
  int         m_st    = 0;
  int         m_cnt   = 0;
  int         m_pos   = 0;
  logic [1:0] m_mode  = 2'd0;
  logic [1:0] m_pmode = 2'd0;
  logic       m_pflag = 1'b0;
  logic       m_tick  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [3:0] pat(input logic [1:0] m, input int p);
    case (m)
      2'd0: return 4'(p % 16);
      2'd1: return 4'(8 >> (p % 4));
      2'd2: begin
        case (p % 6)
          0:       return 4'd8;
          1:       return 4'd4;
          2:       return 4'd2;
          3:       return 4'd1;
          4:       return 4'd2;
          default: return 4'd4;
        endcase
      end
      default: return (p % 2 == 1) ? 4'hF : 4'h0;
    endcase
  endfunction

  task automatic model_step(input logic s, input logic p, input logic ld,
                            input logic [1:0] md, input logic r);
    bit consumed;
    bit tick_now;
    consumed = 1'b0;
    if (r) begin
      m_st = 0; m_cnt = 0; m_pos = 0; m_mode = 0; m_pmode = 0; m_pflag = 0; m_tick = 0;
      return;
    end
    tick_now = (m_st == 1) && (m_cnt == TICK_DIV - 1);
    m_tick = 1'b0;
    case (m_st)
      0: if (s && !p) begin
        m_mode = ld ? md : m_pmode;
        m_pos = 0; m_cnt = 0; consumed = 1'b1; m_st = 1;
      end
      1: begin
        if (p) m_st = 2;
        else if (tick_now) begin
          m_cnt = 0; m_tick = 1'b1;
          if (m_pflag) begin
            m_mode = m_pmode; m_pos = 0; m_pflag = 1'b0;
          end else begin
            m_pos++;
          end
        end else begin
          m_cnt++;
        end
      end
      default: begin
        if (p) begin
          m_st = 0; m_cnt = 0;
        end else if (s) begin
          if (ld || m_pflag) begin
            m_mode = ld ? md : m_pmode;
            m_pos = 0; m_cnt = 0; consumed = 1'b1;
          end
          m_st = 1;
        end
      end
    endcase
    if (ld) m_pmode = md;
    if (consumed) m_pflag = 1'b0;
    else if (ld)  m_pflag = 1'b1;
  endtask

  task automatic cycle(input logic s, input logic p, input logic ld,
                       input logic [1:0] md, input logic r);
    logic [3:0] exp_led;
    bus.start = s; bus.stop = p; bus.mode_load = ld; bus.mode = md; rst_i = r;
    @(posedge iclk);
    model_step(s, p, ld, md, r);
    #1;
    exp_led = (m_st == 0) ? 4'd0 : pat(m_mode, m_pos);
    chk("led",  {28'd0, bus.LED2, bus.LED3, bus.LED4, bus.LED5}, {28'd0, exp_led});
    chk("busy", {31'd0, bus.busy}, {31'd0, (m_st != 0)});
    chk("step_tick", {31'd0, bus.step_tick}, {31'd0, m_tick});
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.mode_load = 1'b0; bus.mode = 2'd0; rst_i = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    idle_n(2);

    // Mode 0 long enough to see the 1111 -> 0000 wrap.
    cycle(1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
    idle_n(70);
    // Start and stop together while running pauses; a second stop clears.
    cycle(1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    idle_n(3);
    cycle(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    idle_n(3);

    // Ping-pong, then a mid-run switch to running light and then blink.
    cycle(1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    idle_n(34);
    cycle(1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
    idle_n(9);
    cycle(1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
    idle_n(12);
    // Pause, idle for a while, resume without a pending mode.
    cycle(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    idle_n(10);
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    idle_n(9);
    // Reset mid-run in ping-pong, then a fresh start in mode 0.
    cycle(1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
    idle_n(22);
    cycle(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    idle_n(9);

    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 7) == 0),
            ($urandom_range(0, 23) == 0),
            ($urandom_range(0, 11) == 0),
            2'($urandom_range(0, 3)),
            ($urandom_range(0, 399) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
# led_seq_ctrl

Pattern sequencer that drives the four board LEDs (LED2..LED5) probed by the on-chip logic analyzer in lab4. It owns the LED resource: a prescaler derives a step tick from `iclk`, and a RUN/PAUSE/IDLE state machine applies one of four selectable patterns. Mode changes arrive through a load strobe and are scheduled to take effect on step boundaries, so every captured LED transition is glitch-free and tick-aligned.

## Interface
- `TICK_DIV`, default 13_500_000: `iclk` cycles per pattern step; legal range ≥ 2. Benches use 4.
- `iclk`  in  1  system clock; all logic on the rising edge.
- `rst_i`  in  1  reset, synchronous and active-high.
- `start`  in  1  single-cycle start/resume request.
- `stop`  in  1  single-cycle pause/clear request.
- `mode`  in  2  pattern select; sampled only when `mode_load`=1.
- `mode_load`  in  1  strobe that captures `mode` into the pending-mode register.
- `busy`  out  1  high when state ≠ IDLE.
- `step_tick`  out  1  one-cycle pulse in the first cycle a new stepped pattern is visible.
- `LED2`, `LED3`, `LED4`, `LED5`  out  1 each  active-high LED drives. Board inversion is handled outside this block.

## Operation
- Internal vector `led[3:0]` = {LED2, LED3, LED4, LED5}; LED2 is the MSB. All outputs are registered.
- Reset values:
  - state = IDLE, `led` = 0000, `busy` = 0, `step_tick` = 0.
  - Prescaler = 0, active mode = 0, pending mode = 0, pending flag = 0, direction = right.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN; the internal tick fires when count = TICK_DIV-1, then the count wraps to 0.
  - Held at 0 in IDLE. Frozen in PAUSE and resumes from its held value.
  - Cleared on every entry to RUN from IDLE, and on a mode restart.
- Modes (initial pattern, then one update per tick):
  - 0, binary count: starts at 0000, `led` +1 per tick; 1111 wraps to 0000 (4-bit modulo).
  - 1, running light: starts at 1000, rotates right (1000→0100→0010→0001→1000).
  - 2, ping-pong: starts at 1000 with direction right; sequence 1000,0100,0010,0001,0010,0100,1000,… Direction flips when the new value reaches 0001 or 1000.
  - 3, blink: starts at 0000, `led` = ~`led` per tick.
- State machine:
  - IDLE + `start` → RUN. Active mode ← pending mode, `led` ← initial pattern, prescaler ← 0, pending flag cleared.
  - RUN + `stop` → PAUSE. `led` holds its value.
  - PAUSE + `start` → RUN. If the pending flag is set, the new mode is applied as in the IDLE case (restart); otherwise the pattern resumes and the prescaler continues.
  - PAUSE + `stop` → IDLE. `led` ← 0000, prescaler ← 0.
  - `start` in RUN and `stop` in IDLE are ignored.
- Mode scheduling:
  - `mode_load` always writes the pending mode and sets the pending flag; a later load overwrites an earlier one.
  - In RUN, a pending mode is applied on the next tick in place of a normal step: `led` ← initial pattern of the new mode, direction ← right, pending flag cleared. That tick still pulses `step_tick`.
  - In IDLE or PAUSE, the pending mode is held until the next `start`.
- Simultaneous events:
  - `start` and `stop` in the same cycle: `stop` wins.
  - `mode_load` and `start` in the same cycle: the newly loaded mode is used.
  - `mode_load` on a tick cycle in RUN: this tick applies the previously pending mode (or a normal step if none); the new value waits for the next tick.
  - `stop` on a tick cycle: the state becomes PAUSE and the step is suppressed (no LED change, no `step_tick`).
- `rst_i` overrides everything in any state and returns all registers to their reset values on the next edge.

## Timing
- `start` sampled at edge n: `busy` = 1 and the initial pattern are visible after edge n; the first step follows TICK_DIV cycles later.
- Steady RUN: one `led` update every TICK_DIV cycles exactly. `step_tick` is high for exactly one cycle, aligned with the new value.
- `stop` sampled at edge n: the state changes after edge n. No further `led` change occurs from edge n+1 onward; when `stop` lands on a tick cycle, no change occurs after edge n either.
- Resume without a pending mode: the remaining interval is TICK_DIV minus the cycles already counted before the pause.
- Latency from `mode_load` to the new pattern in RUN: ≤ TICK_DIV cycles, always on a tick.

## Test plan
- Reset, then `start` with mode 0, TICK_DIV=4 → `led` = 0000, 0001, 0010, … at 4-cycle spacing; 1111 → 0000 wrap after 16 ticks; `step_tick` pulses on each step.
- Mode 2 run for 8 ticks → 1000,0100,0010,0001,0010,0100,1000,0100; `busy` = 1 throughout.
- RUN with mode 1 at 0010, `mode_load` with mode = 3 two cycles before a tick → 0010 held until the tick, then 0000, 1111 on the following tick.
- `stop` on a tick cycle at `led` = 0100, then `start` 10 cycles later → `led` stays 0100; no `step_tick` while paused; the next step comes at the correct resumed spacing.
- `start` and `stop` in the same cycle while RUN → PAUSE. A second `stop` → IDLE with `led` = 0000 and `busy` = 0.
- `rst_i` asserted mid-RUN in mode 2, direction left → the next cycle shows all outputs 0 and state IDLE; `start` afterwards begins mode 0 at 0000.
